// File: rtl/data_mem_if.sv
// Request/response bus between a memory client (master) and data_mem_unit (slave).
interface data_mem_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic                    req_valid;
  logic                    req_ready;
  logic                    req_we;
  logic [ADDR_WIDTH-1:0]   req_addr;
  logic [DATA_WIDTH/8-1:0] req_sel;
  logic [DATA_WIDTH-1:0]   req_wdata;
  logic                    resp_valid;
  logic                    resp_ready;
  logic [DATA_WIDTH-1:0]   resp_rdata;
  logic                    resp_err;

  modport master (
    output req_valid, req_we, req_addr, req_sel, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_sel, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/data_mem_unit.sv
// Byte-lane word memory with one-cycle registered responses and range checking.
// Define DATA_MEM_CLEAR_EN to zero the whole array after every reset (INIT sweep).
module data_mem_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 1024,
  parameter int ADDR_WIDTH = 32
) (
  input  logic       clk,
  input  logic       rst,
  data_mem_if.slave  bus,
  output logic       init_busy
);
  localparam int BYTES = DATA_WIDTH / 8;
  localparam int OFS   = $clog2(BYTES);
  localparam int IDX   = $clog2(DEPTH);
  localparam int SHIFT = IDX + OFS;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic                  respValid_q, respValid_d;
  logic                  respErr_q, respErr_d;
  logic [DATA_WIDTH-1:0] respRdata_q, respRdata_d;
  logic [IDX-1:0]        wordIdx;
  logic                  outOfRange;
  logic                  running;
  logic                  accept;

  assign wordIdx    = bus.req_addr[SHIFT-1:OFS];
  assign outOfRange = (bus.req_addr >> SHIFT) != '0;

`ifdef DATA_MEM_CLEAR_EN
  typedef enum logic {INIT, RUN} state_t;

  state_t         state_q;
  logic [IDX-1:0] sweep_q;
  logic           busy_q;
  logic           sweepWr;

  // Sweep writes word sweep_q each INIT cycle and hands over to RUN after the last word.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= INIT;
      sweep_q <= '0;
      busy_q  <= 1'b1;
    end else begin
      case (state_q)
        INIT: begin
          sweep_q <= sweep_q + 1'b1;
          if (sweep_q == IDX'(DEPTH - 1)) begin
            state_q <= RUN;
            busy_q  <= 1'b0;
          end
        end
        RUN: state_q <= RUN;
        default: state_q <= INIT;
      endcase
    end
  end

  assign sweepWr   = (state_q == INIT) && !rst;
  assign running   = (state_q == RUN) && !rst;
  assign init_busy = busy_q;
`else
  assign running   = !rst;
  assign init_busy = 1'b0;
`endif

  assign bus.req_ready = running && (!respValid_q || bus.resp_ready);
  assign accept        = bus.req_valid && bus.req_ready;

  // No reset on the array: contents survive rst unless the clear sweep is built in.
  always_ff @(posedge clk) begin
`ifdef DATA_MEM_CLEAR_EN
    if (sweepWr) begin
      mem_q[sweep_q] <= '0;
    end else
`endif
    if (accept && bus.req_we && !outOfRange) begin
      for (int i = 0; i < BYTES; i++) begin
        if (bus.req_sel[i]) mem_q[wordIdx][8*i +: 8] <= bus.req_wdata[8*i +: 8];
      end
    end
  end

  always_comb begin
    respValid_d = respValid_q;
    respErr_d   = respErr_q;
    respRdata_d = respRdata_q;
    if (accept) begin
      respValid_d = 1'b1;
      respErr_d   = outOfRange;
      respRdata_d = (!bus.req_we && !outOfRange) ? mem_q[wordIdx] : '0;
    end else if (bus.resp_ready) begin
      respValid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      respValid_q <= 1'b0;
      respErr_q   <= 1'b0;
      respRdata_q <= '0;
    end else begin
      respValid_q <= respValid_d;
      respErr_q   <= respErr_d;
      respRdata_q <= respRdata_d;
    end
  end

  assign bus.resp_valid = respValid_q;
  assign bus.resp_err   = respErr_q;
  assign bus.resp_rdata = respRdata_q;
endmodule
